distinct_arb: RTL

DISTINCT_ARB -- requirements
Module: distinct_arb

---
 rtl/distinct_arb.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/distinct_arb.sv
// Arbitrates N_REQ key streams onto one shared distinct engine, one owner at a time.
// Each owner's burst is drained and followed by an engine table clear before re-arbitration.
module distinct_arb #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned MAX_OUT    = 32,
  parameter int unsigned CLR_CYCLES = 4,
  parameter int unsigned KEY_W      = 32
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  // Requester key streams
  input  logic [N_REQ-1:0]                s_req_valid,
  output logic [N_REQ-1:0]                s_req_ready,
  input  logic [N_REQ-1:0][KEY_W-1:0]     s_req_key,
  input  logic [N_REQ-1:0]                s_req_last,
  // Per-requester results
  output logic [N_REQ-1:0]                m_rsp_valid,
  input  logic [N_REQ-1:0]                m_rsp_ready,
  output logic [N_REQ-1:0][KEY_W-1:0]     m_rsp_key,
  output logic [N_REQ-1:0]                m_rsp_last,
  output logic [N_REQ-1:0]                m_rsp_hit,
  // Engine side
  output logic                            m_dist_valid,
  input  logic                            m_dist_ready,
  output logic [KEY_W-1:0]                m_dist_key,
  output logic                            m_dist_last,
  output logic                            m_dist_hit,
  input  logic                            s_dist_valid,
  output logic                            s_dist_ready,
  input  logic [KEY_W-1:0]                s_dist_key,
  input  logic                            s_dist_last,
  input  logic                            s_dist_hit,
  // Control and status
  input  logic                            clear_req,
  output logic                            m_clear,
  output logic                            busy,
  output logic [$clog2(MAX_OUT+1)-1:0]    outstanding,
  output logic                            err
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned OutW = $clog2(MAX_OUT + 1);
  localparam int unsigned CntW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StClear} state_e;

  state_e            r_state, w_state_d;
  logic [IdxW-1:0]   r_owner, w_owner_d;
  logic [IdxW-1:0]   r_rr_ptr, w_rr_ptr_d;
  logic [OutW-1:0]   r_outstanding, w_outstanding_d;
  logic [CntW-1:0]   r_clr_cnt, w_clr_cnt_d;
  logic              r_pending, w_pending_d;
  logic              r_err, w_err_d;

  logic              w_room;
  logic              w_dist_fire;
  logic              w_rsp_fire;
  logic              w_err_evt;
  logic [IdxW-1:0]   w_pick;
  int                w_idx;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= StIdle;
      r_owner       <= '0;
      r_rr_ptr      <= '0;
      r_outstanding <= '0;
      r_clr_cnt     <= '0;
      r_pending     <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_owner       <= w_owner_d;
      r_rr_ptr      <= w_rr_ptr_d;
      r_outstanding <= w_outstanding_d;
      r_clr_cnt     <= w_clr_cnt_d;
      r_pending     <= w_pending_d;
      r_err         <= w_err_d;
    end
  end

  // First valid requester at or after rr_ptr; descending scan lets the nearest win.
  always_comb begin
    w_pick = r_rr_ptr;
    w_idx  = 0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      w_idx = (int'(r_rr_ptr) + i) % int'(N_REQ);
      if (s_req_valid[IdxW'(w_idx)]) w_pick = IdxW'(w_idx);
    end
  end

  // Data paths: purely combinational, no buffering.
  always_comb begin
    w_room       = (r_outstanding < OutW'(MAX_OUT));
    m_dist_key   = s_req_key[r_owner];
    m_dist_last  = s_req_last[r_owner];
    m_dist_hit   = 1'b0;
    m_dist_valid = (r_state == StRun) && s_req_valid[r_owner] && w_room;
    s_req_ready  = '0;
    s_req_ready[r_owner] = (r_state == StRun) && m_dist_ready && w_room;
    w_dist_fire  = m_dist_valid && m_dist_ready;

    m_rsp_key    = {N_REQ{s_dist_key}};
    m_rsp_last   = {N_REQ{s_dist_last}};
    m_rsp_hit    = {N_REQ{s_dist_hit}};
    m_rsp_valid  = '0;
    // Stray responses are swallowed; gated by reset so ready stays low while held.
    s_dist_ready = aresetn;
    if (r_outstanding != '0) begin
      m_rsp_valid[r_owner] = s_dist_valid;
      s_dist_ready         = m_rsp_ready[r_owner];
    end
    w_rsp_fire = s_dist_valid && s_dist_ready && (r_outstanding != '0);
    w_err_evt  = s_dist_valid && (r_outstanding == '0);
  end

  always_comb begin
    w_state_d       = r_state;
    w_owner_d       = r_owner;
    w_rr_ptr_d      = r_rr_ptr;
    w_clr_cnt_d     = r_clr_cnt;
    w_pending_d     = r_pending;
    w_err_d         = r_err | w_err_evt;
    w_outstanding_d = r_outstanding;

    unique case ({w_dist_fire, w_rsp_fire})
      2'b10:   w_outstanding_d = r_outstanding + OutW'(1);
      2'b01:   w_outstanding_d = r_outstanding - OutW'(1);
      default: w_outstanding_d = r_outstanding;
    endcase

    unique case (r_state)
      StIdle: begin
        if (clear_req) begin
          w_state_d   = StDrain;
          w_pending_d = 1'b1;
        end else if (|s_req_valid) begin
          w_owner_d = w_pick;
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (clear_req) w_pending_d = 1'b1;
        if (w_dist_fire && m_dist_last) begin
          w_state_d  = StDrain;
          w_rr_ptr_d = (r_owner == IdxW'(N_REQ - 1)) ? '0 : r_owner + IdxW'(1);
        end
      end
      StDrain: begin
        if (clear_req) w_pending_d = 1'b1;
        if (r_outstanding == '0) begin
          w_state_d   = StClear;
          w_clr_cnt_d = '0;
          w_pending_d = 1'b0;
        end
      end
      StClear: begin
        if (r_clr_cnt == CntW'(CLR_CYCLES - 1)) w_state_d = StIdle;
        else                                     w_clr_cnt_d = r_clr_cnt + CntW'(1);
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign m_clear     = (r_state == StClear);
  assign busy        = (r_state != StIdle);
  assign outstanding = r_outstanding;
  assign err         = r_err;

endmodule
